// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, baud select codes and baud divisor helper
// for the buffered UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

   localparam logic [2:0] BAUD_9600   = 3'd0;
   localparam logic [2:0] BAUD_19200  = 3'd1;
   localparam logic [2:0] BAUD_38400  = 3'd2;
   localparam logic [2:0] BAUD_57600  = 3'd3;
   localparam logic [2:0] BAUD_115200 = 3'd4;

   // Divisor for the baud counter: a bit lasts DIV+1 clocks. Codes 5..7 fall back to 9600.
   function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [2:0] sel);
      int unsigned baud;
      baud = (sel == BAUD_19200)  ? 19200  :
             (sel == BAUD_38400)  ? 38400  :
             (sel == BAUD_57600)  ? 57600  :
             (sel == BAUD_115200) ? 115200 : 9600;
      return clk_freq / baud - 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through byte FIFO.
// Ports:
//   Clk, Rst_n       clock, asynchronous active-low reset
//   wr_en, wr_data   enqueue strobe and byte; dropped when full unless a pop happens in the same cycle
//   rd_en            pop the head (ignored when empty)
//   rd_data          head byte, valid whenever empty is low
//   level            bytes stored, 0..FIFO_DEPTH
//   full, empty      level == FIFO_DEPTH, level == 0
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int AW         = 4
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0] level_q, level_d;
   logic        do_wr, do_rd;

   assign full    = level_q == (AW+1)'(FIFO_DEPTH);
   assign empty   = level_q == '0;
   assign level   = level_q;
   assign rd_data = mem_q[rptr_q];
   assign do_rd   = rd_en & ~empty;
   // A pop frees the head slot this cycle, so a write to a full FIFO still lands.
   assign do_wr   = wr_en & (~full | do_rd);

   always_comb begin
      mem_d   = mem_q;
      if (do_wr) mem_d[wptr_q] = wr_data;
      wptr_d  = do_wr ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = do_rd ? rptr_q + AW'(1) : rptr_q;
      level_d = level_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
   end

   always_ff @(posedge Clk) mem_q <= mem_d;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter sending back-to-back 8N1 frames.
// Optional even/odd parity bit when UART_TX_PARITY_EN is defined.
// Ports:
//   Clk, Rst_n    clock, asynchronous active-low reset
//   baud_set      0=9600 1=19200 2=38400 3=57600 4=115200 5..7=9600, latched at frame start
//   wr_data/wr_en byte enqueue
//   parity_odd    (UART_TX_PARITY_EN only) invert the even parity bit, latched at frame start
//   full          FIFO full
//   overflow      pulse in the cycle a write is dropped
//   fifo_level    bytes queued, excluding the one in the shifter
//   Rs232_Tx      serial line, idle high
//   Tx_Done       pulse on the last clock of each stop bit
//   uart_state    high while a frame is on the line
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int          FIFO_DEPTH = 16,
   parameter int          AW         = 4
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic [2:0]    baud_set,
   input  logic [7:0]    wr_data,
   input  logic          wr_en,
`ifdef UART_TX_PARITY_EN
   input  logic          parity_odd,
`endif
   output logic          full,
   output logic          overflow,
   output logic [AW:0]   fifo_level,
   output logic          Rs232_Tx,
   output logic          Tx_Done,
   output logic          uart_state
);

   localparam int CW = $clog2(CLK_FREQ / 9600);

`ifdef UART_TX_PARITY_EN
   localparam tx_state_e AFTER_DATA = PARITY;
`else
   localparam tx_state_e AFTER_DATA = STOP;
`endif

   tx_state_e      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d, div_q, div_d;
   logic [7:0]     sh_q, sh_d;
   logic [2:0]     idx_q, idx_d;
   logic           par_bit;
   logic           bit_end, pop, empty;
   logic [7:0]     rd_data;

   uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (rd_data),
      .level   (fifo_level),
      .full    (full),
      .empty   (empty)
   );

`ifdef UART_TX_PARITY_EN
   logic par_q, par_d;
   assign par_bit = par_q;
`else
   assign par_bit = 1'b1;
`endif

   assign bit_end    = cnt_q == div_q;
   assign Tx_Done    = state_q == STOP && bit_end;
   assign uart_state = state_q != IDLE;
   // Popping at the end of a stop bit starts the next frame with no idle gap.
   assign pop        = ~empty & (state_q == IDLE | Tx_Done);
   assign overflow   = wr_en & full & ~pop;

   always_comb begin
      Rs232_Tx = (state_q == START)  ? 1'b0     :
                 (state_q == DATA)   ? sh_q[0]  :
                 (state_q == PARITY) ? par_bit  : 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + CW'(1);
      div_d   = div_q;
      sh_d    = sh_q;
      idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         START:   if (bit_end) state_d = DATA;
         DATA:    if (bit_end) begin
                     sh_d  = sh_q >> 1;
                     idx_d = idx_q + 3'd1;
                     if (idx_q == 3'd7) state_d = AFTER_DATA;
                  end
         PARITY:  if (bit_end) state_d = STOP;
         STOP:    if (bit_end) state_d = IDLE;
         default: ;
      endcase
      if (pop) begin
         state_d = START;
         cnt_d   = '0;
         sh_d    = rd_data;
         idx_d   = '0;
         div_d   = CW'(baud_div(CLK_FREQ, baud_set));
`ifdef UART_TX_PARITY_EN
         par_d   = ^rd_data ^ parity_odd;
`endif
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         sh_q    <= '0;
         idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         sh_q    <= sh_d;
         idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized and directed bench for uart_tx_buffered with a frame-level reference model.
module tb_uart_tx_buffered;

   localparam int unsigned CLK_FREQ = 1_152_000;
   localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0, rst_n = 1'b1, wr_en = 1'b0;
   logic [2:0] baud_set = 3'd4;
   logic [7:0] wr_data = 8'h00;
`ifdef UART_TX_PARITY_EN
   logic       parity_odd = 1'b0;
`endif
   logic       full, overflow, tx, tx_done, ustate;
   logic [4:0] level;

   int errs = 0, checks = 0, cyc = 0, n_done = 0, n_ovf = 0;

   uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(DEPTH), .AW(4)) dut (
      .Clk        (clk),
      .Rst_n      (rst_n),
      .baud_set   (baud_set),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
`ifdef UART_TX_PARITY_EN
      .parity_odd (parity_odd),
`endif
      .full       (full),
      .overflow   (overflow),
      .fifo_level (level),
      .Rs232_Tx   (tx),
      .Tx_Done    (tx_done),
      .uart_state (ustate)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         if (errs <= 40) $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int bit_clocks(input logic [2:0] s);
      case (s)
         3'd1: return CLK_FREQ / 19200;
         3'd2: return CLK_FREQ / 38400;
         3'd3: return CLK_FREQ / 57600;
         3'd4: return CLK_FREQ / 115200;
         default: return CLK_FREQ / 9600;
      endcase
   endfunction

   // Reference model: a byte queue plus the current frame as a bit vector and elapsed clocks.
   logic [7:0]    mq[$];
   logic [7:0]    m_d;
   logic [NB-1:0] m_fb;
   bit            m_busy = 0, m_last, m_pop, m_full;
   int            m_bt = 1, m_t = 0;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         mq.delete();
         m_busy = 0;
         m_t    = 0;
      end
      m_last = m_busy && m_t == NB * m_bt - 1;
      m_pop  = rst_n && mq.size() > 0 && (!m_busy || m_last);
      m_full = mq.size() == DEPTH;
      chk("Rs232_Tx", tx, m_busy ? m_fb[m_t / m_bt] : 1'b1);
      chk("Tx_Done", tx_done, m_last);
      chk("uart_state", ustate, m_busy);
      chk("fifo_level", level, mq.size());
      chk("full", full, m_full);
      chk("overflow", overflow, rst_n && wr_en && m_full && !m_pop);
      if (tx_done === 1'b1) n_done++;
      if (overflow === 1'b1) n_ovf++;
      if (rst_n) begin
         if (m_pop) m_d = mq.pop_front();
         if (wr_en && mq.size() < DEPTH) mq.push_back(wr_data);
         if (m_pop) begin
            m_bt = bit_clocks(baud_set);
`ifdef UART_TX_PARITY_EN
            m_fb = {1'b1, (^m_d) ^ parity_odd, m_d, 1'b0};
`else
            m_fb = {1'b1, m_d, 1'b0};
`endif
            m_t    = 0;
            m_busy = 1;
         end else if (m_last) m_busy = 0;
         else if (m_busy) m_t++;
      end
   end

   // Line receiver: samples each bit mid-way at a bit time the test sets in advance.
   bit            mon_en = 1, r_on = 0;
   int            mon_bt = 10, r_bt = 1, r_t = 0, r_start = 0;
   logic [NB-1:0] r_bits;
   logic [NB-1:0] rx_q[$];
   int            starts[$];

   initial forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) r_on = 0;
      else begin
         if (!r_on && tx === 1'b0) begin
            r_on    = 1;
            r_t     = 0;
            r_bt    = mon_bt;
            r_start = cyc;
         end else if (r_on) r_t++;
         if (r_on && r_t % r_bt == r_bt / 2) r_bits[r_t / r_bt] = tx;
         if (r_on && r_t == NB * r_bt - 1) begin
            chk("Tx_Done_at_stop_end", tx_done, 1);
            rx_q.push_back(r_bits);
            starts.push_back(r_start);
            r_on = 0;
         end
      end
   end

   task automatic put(input logic [7:0] d);
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = d;
   endtask

   task automatic stop_wr();
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      repeat (3) @(negedge clk);
      while ((ustate !== 1'b0 || level !== 5'd0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("idle_within_budget", n < budget, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      starts.delete();
   endtask

   int w, d0, o0;

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_tx", tx, 1);
      chk("reset_state", ustate, 0);
      chk("reset_level", level, 0);
      chk("reset_full", full, 0);
      chk("reset_done", tx_done, 0);
      chk("reset_overflow", overflow, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single byte at 115200 (10 clocks per bit at this clock).
      baud_set = 3'd4; mon_bt = 10; clear_rx(); d0 = n_done;
      put(8'hAA); w = cyc; stop_wr();
      wait_idle(500);
      chk("t1_frames", rx_q.size(), 1);
      if (rx_q.size() > 0) begin
         chk("t1_frame_bits", {rx_q[0][NB-1], rx_q[0][8:0]}, 10'b1101010100);
         chk("t1_latency", starts[0] - w, 2);
      end
      chk("t1_done_pulses", n_done - d0, 1);

      // Back-to-back frames with no gap.
      clear_rx();
      put(8'hAA); put(8'h55); stop_wr();
      wait_idle(1000);
      chk("t2_frames", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         chk("t2_byte0", rx_q[0][8:1], 8'hAA);
         chk("t2_byte1", rx_q[1][8:1], 8'h55);
         chk("t2_gap", starts[1] - starts[0], NB * 10);
      end

      // Fill and overflow at 9600 (120 clocks per bit).
      baud_set = 3'd0; mon_bt = 120; clear_rx(); o0 = n_ovf;
      for (int i = 0; i < 17; i++) put(8'(i));
      put(8'h11);
      @(negedge clk);
      chk("t3_full", full, 1);
      chk("t3_overflow_pulse", overflow, 1);
      chk("t3_level", level, 16);
      stop_wr();
      wait_idle(17 * NB * 120 + 500);
      chk("t3_frames", rx_q.size(), 17);
      chk("t3_overflow_count", n_ovf - o0, 1);
      for (int i = 0; i < 17 && i < rx_q.size(); i++) chk("t3_byte", rx_q[i][8:1], i);

      // Baud change mid-frame only affects the following frame.
      clear_rx();
      put(8'h0F); stop_wr();
      repeat (300) @(posedge clk);
      #1 baud_set = 3'd4; mon_bt = 10;
      put(8'hF0); stop_wr();
      wait_idle(3000);
      chk("t4_frames", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         chk("t4_byte0", rx_q[0][8:1], 8'h0F);
         chk("t4_byte1", rx_q[1][8:1], 8'hF0);
         chk("t4_slow_frame_len", starts[1] - starts[0], NB * 120);
      end

      // Reset in the middle of a frame with three bytes queued.
      clear_rx();
      put(8'hAA); put(8'h55); put(8'h33); put(8'h11); stop_wr();
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("t5_level_before", level, 3);
      chk("t5_busy_before", ustate, 1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("t5_tx_in_reset", tx, 1);
      chk("t5_level_in_reset", level, 0);
      chk("t5_state_in_reset", ustate, 0);
      d0 = n_done;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("t5_no_done", n_done - d0, 0);
      chk("t5_no_frames", rx_q.size(), 0);
      chk("t5_line_idle", tx, 1);

`ifdef UART_TX_PARITY_EN
      clear_rx(); baud_set = 3'd4; mon_bt = 10;
      parity_odd = 1'b0; put(8'h07); stop_wr();
      wait_idle(500);
      parity_odd = 1'b1; put(8'h07); stop_wr();
      wait_idle(500);
      chk("t7_frames", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         chk("t7_even_parity", rx_q[0][9], 1);
         chk("t7_odd_parity", rx_q[1][9], 0);
         chk("t7_data", rx_q[1][8:1], 8'h07);
      end
`endif

      // Random traffic, checked cycle by cycle against the model only.
      mon_en = 0;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            wr_en   = $urandom_range(0, 2) == 0;
            wr_data = 8'($urandom);
`ifdef UART_TX_PARITY_EN
            parity_odd = 1'($urandom);
`endif
            if ($urandom_range(0, 19) == 0)
               baud_set = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(3, 4));
         end
         stop_wr();
         wait_idle(25000);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter. Accepts bytes from host logic via a write strobe into an internal FIFO, then serialises them as 8N1 frames on Rs232_Tx at a runtime-selectable baud rate.
- Transmit-side counterpart to uart_rx_top. Its line output drives a uart_rx_top instance directly in loopback.
- Unlike uart_byte_tx, it queues multiple bytes and sends them back-to-back with no idle gap.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz, used for the baud divisor table.
- FIFO_DEPTH, 16, byte entries in the transmit FIFO; power of two, minimum 2.
- AW, 4, FIFO address width; must equal log2(FIFO_DEPTH).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- baud_set  in  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe, one byte per cycle high.
- full  out  1  FIFO full; a write while full is dropped.
- overflow  out  1  one-cycle pulse when a write is dropped.
- fifo_level  out  AW+1  bytes currently queued, excluding the byte being shifted.
- Rs232_Tx  out  1  serial line, idle high.
- Tx_Done  out  1  one-cycle pulse at the last clock of each stop bit.
- uart_state  out  1  high from the first start-bit clock to the last stop-bit clock of any frame.

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-low (Rst_n).
- Reset values: Rs232_Tx=1, Tx_Done=0, uart_state=0, full=0, overflow=0, fifo_level=0. FIFO pointers cleared; FSM in IDLE.
- Reset asserted mid-frame aborts the frame immediately: line returns high and queued bytes are discarded.
- Baud divisor: DIV = CLK_FREQ/baud - 1. At 50 MHz: 5207, 2603, 1301, 867, 433.
  - Bit time is DIV+1 clocks; 115200 gives 434 clocks.
  - baud_set is latched at each frame start; changes mid-frame take effect on the next frame.
- FSM states IDLE -> START -> DATA -> STOP -> (START | IDLE).
  - IDLE: line high. When FIFO is non-empty: pop the head into the shift register, latch the divisor, go to START on the next clock.
  - Latency: 2 clocks from the wr_en cycle into an empty idle block to the line falling.
  - START: line 0 for one bit time.
  - DATA: 8 bits, LSB first, each one bit time; 3-bit bit index.
  - STOP: line 1 for one bit time. Tx_Done pulses on its final clock.
  - At end of STOP with FIFO non-empty: pop and go to START on the next clock, so the frame gap is exactly zero extra bit time. Otherwise go to IDLE.
- FIFO: synchronous, first-word fall-through.
  - full = (level == FIFO_DEPTH).
  - A write and a pop in the same cycle are both honoured, including when full (the level stays at FIFO_DEPTH) and when empty-then-write (no pop of invalid data; the pop needs non-empty in the prior cycle).
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: pulses only when wr_en=1, full=1 and no pop occurs in that cycle.
- Baud counter: counts 0..DIV, reloads at DIV. Held at 0 in IDLE.

Optional Feature:
- Macro UART_TX_PARITY_EN.
  - When defined: adds input parity_odd (1 bit) and a PARITY state between DATA and STOP. The state sends XOR of the data bits (even parity), inverted when parity_odd=1, for one bit time; frames become 11 bits. parity_odd is latched at frame start.
  - When undefined: port and state are absent; frames are 8N1, 10 bits.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - baud_set codes as localparams;
  - a function returning DIV from CLK_FREQ and baud_set.
- Sub-module uart_tx_fifo: the synchronous FWFT byte FIFO with level/full/empty outputs, parameterised by FIFO_DEPTH/AW.
- FSM and shift register stay in the top.

Test Plan:
- Reset then single byte: baud_set=4, write 0xAA. Line falls 2 clocks later, then sends 0,0,1,0,1,0,1,0,1,1 at 434 clocks per bit. Tx_Done pulses once, 4340 clocks after the falling edge minus 1. uart_state high throughout.
- Back-to-back: write 0xAA and 0x55 on consecutive clocks. Two frames are sent with the second start bit beginning the clock after the first stop bit ends. uart_rx_top in loopback receives 0xAA then 0x55.
- Fill and overflow: FIFO_DEPTH=16, write 18 bytes 0x00..0x11 in consecutive cycles while baud_set=0.
  - The first byte is popped to the shifter, so 16 more are queued and full asserts.
  - The 18th write is dropped with an overflow pulse.
  - Exactly 17 frames are sent, 0x00..0x10 in order.
- Baud switch: send 0x0F at baud_set=0 and change baud_set to 4 mid-frame. That frame keeps 5208 clocks per bit; the next byte, 0xF0, uses 434 clocks per bit.
- Reset mid-frame: assert Rst_n=0 during DATA of 0xAA with 3 bytes queued. Rs232_Tx=1 and fifo_level=0 immediately. No Tx_Done after reset release; the line stays idle.
- With UART_TX_PARITY_EN: send 0x07 with parity_odd=0 -> parity bit 1, 11-bit frame. Send 0x07 with parity_odd=1 -> parity bit 0.
